uart1_tx_avalon: RTL and testbench



---
 rtl/uart1_tx_avalon_if.sv | 21 ++
 rtl/uart1_tx_avalon.sv | 199 +++++++++++++++++++
 tb/tb_uart1_tx_avalon.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart1_tx_avalon_if.sv
// Avalon-MM slave bus and serial pins of the UART1 transmitter.
// The master modport is the CPU/bench side; the slave modport is the UART.
interface uart1_tx_avalon_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        txd;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, txd, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, txd, irq
   );
endinterface

// File: rtl/uart1_tx_avalon.sv
// UART1 transmitter: Avalon-MM register file, small TX FIFO and an 8N1 shift FSM.
// The FSM drains the FIFO back-to-back and a level irq flags an idle, empty transmitter.
module uart1_tx_avalon #(
   parameter int FIFO_DEPTH  = 4,
   parameter int DEFAULT_DIV = 434
) (
   input logic             clk,
   input logic             reset_n,
   uart1_tx_avalon_if.slave bus
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] baud_q, baud_d;
   logic [15:0] div_act_q, div_act_d;
   logic [15:0] div_q, div_d;
   logic        irq_en_q, irq_en_d;
   logic        overflow_q, overflow_d;
   logic        txd_q, txd_d;
   logic        irq_q, irq_d;
   logic [31:0] readdata_q, readdata_d;
   logic [4:0]  level_q, level_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];

   logic wr, push_req, push, pop, full, empty, busy, baud_end;
   logic unused_wdata;

   assign unused_wdata = ^bus.writedata[31:16];

   assign wr       = bus.chipselect & ~bus.write_n;
   assign push_req = wr && (bus.address == 2'd0);
   assign full     = (level_q == 5'(FIFO_DEPTH));
   assign empty    = (level_q == 5'd0);
   assign push     = push_req & ~full;
   assign busy     = (state_q != S_IDLE);
   assign baud_end = (baud_q == div_act_q - 16'd1);

   // FIFO storage and pointers; a full FIFO drops the push even if a pop happens alongside.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.writedata[7:0];
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + {4'd0, push} - {4'd0, pop};
   end

   always_comb begin
      div_d      = div_q;
      irq_en_d   = irq_en_q;
      overflow_d = overflow_q | (push_req & full);
      if (wr && (bus.address == 2'd1) && bus.writedata[3]) begin
         overflow_d = 1'b0;
      end
      if (wr && (bus.address == 2'd2)) begin
         div_d = (bus.writedata[15:0] == 16'd0) ? 16'd1 : bus.writedata[15:0];
      end
      if (wr && (bus.address == 2'd3)) begin
         irq_en_d = bus.writedata[0];
      end
   end

   // Frame FSM; a pop from IDLE or the end of STOP loads the next byte and relatches the divisor.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      baud_d    = baud_q;
      div_act_d = div_act_q;
      pop       = 1'b0;
      txd_d     = 1'b1;
      case (state_q)
         S_IDLE: begin
            pop = ~empty;
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = 16'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d    = 16'd0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = 16'd0;
               if (empty) begin
                  state_d = S_IDLE;
               end else begin
                  pop = 1'b1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (pop) begin
         shift_d   = mem_q[rd_ptr_q];
         div_act_d = div_q;
         bit_cnt_d = 3'd0;
         baud_d    = 16'd0;
         state_d   = S_START;
      end
      // txd is registered from the next state so the line moves together with the state.
      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_comb begin
      irq_d      = irq_en_q & empty & ~busy;
      readdata_d = 32'd0;
      case (bus.address)
         2'd0:    readdata_d = {27'd0, level_q};
         2'd1:    readdata_d = {28'd0, overflow_q, empty, full, busy};
         2'd2:    readdata_d = {16'd0, div_q};
         default: readdata_d = {31'd0, irq_en_q};
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         shift_q    <= 8'd0;
         bit_cnt_q  <= 3'd0;
         baud_q     <= 16'd0;
         div_act_q  <= 16'(DEFAULT_DIV);
         div_q      <= 16'(DEFAULT_DIV);
         irq_en_q   <= 1'b0;
         overflow_q <= 1'b0;
         txd_q      <= 1'b1;
         irq_q      <= 1'b0;
         readdata_q <= 32'd0;
         level_q    <= 5'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_q     <= baud_d;
         div_act_q  <= div_act_d;
         div_q      <= div_d;
         irq_en_q   <= irq_en_d;
         overflow_q <= overflow_d;
         txd_q      <= txd_d;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
         level_q    <= level_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign bus.txd      = txd_q;
   assign bus.irq      = irq_q;

endmodule

// File: tb/tb_uart1_tx_avalon.sv
// Bench for uart1_tx_avalon: register table, then frame-level scenarios checked by a
// serial-line monitor that pops expected {byte, divisor} records from a scoreboard.
module tb_uart1_tx_avalon;

   typedef struct {
      logic [7:0] data;
      int         div;
   } exp_t;

   typedef struct {
      bit          is_wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   frames_done = 0;
   int   div_model = 434;
   int   last_wr_cyc = 0;
   exp_t sb_q[$];
   int   starts[$];
   vec_t vecs[16];

   uart1_tx_avalon_if bus_if ();

   uart1_tx_avalon #(.FIFO_DEPTH(4), .DEFAULT_DIV(434)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.address    = a;
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(posedge clk);
      #1;
      last_wr_cyc       = cyc;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      if (a == 2'd2) div_model = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b1;
      @(posedge clk);
      #1;
      d                 = bus_if.readdata;
      bus_if.chipselect = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, output logic [31:0] rd);
      rd = 32'd0;
      if (v.is_wr) busWrite(v.addr, v.wdata);
      else         busRead(v.addr, rd);
   endtask

   task automatic sendByte(input logic [7:0] b, input bit accept);
      exp_t e;
      e.data = b;
      e.div  = div_model;
      if (accept) sb_q.push_back(e);
      busWrite(2'd0, {24'd0, b});
   endtask

   // Holds STATUS on the bus and returns the cycle of the last busy=1 readback.
   task automatic waitBusyEnd(input int budget, output int last);
      bit seen = 0;
      bit done = 0;
      last = 0;
      bus_if.address = 2'd1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.readdata[0]) begin
            seen = 1;
            last = cyc;
         end else if (seen) begin
            done = 1;
            break;
         end
      end
      checkOutput("busy_end_reached", done, 1);
   endtask

   task automatic waitFrames(input int target, input int budget);
      for (int i = 0; i < budget && frames_done < target; i++) begin
         @(posedge clk);
      end
      checkOutput("frames_done", frames_done, target);
   endtask

   function automatic int startAt(input int i);
      return (i < starts.size()) ? starts[i] : -1000000;
   endfunction

   // Serial-line monitor: compares every cycle of a frame against the 8N1 waveform.
   always begin : monitor
      exp_t e;
      int bad, idx;
      logic [7:0] got;
      logic eb;
      bit aborted;
      @(negedge clk);
      if (reset_n === 1'b1 && bus_if.txd === 1'b0) begin
         starts.push_back(cyc);
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_frame", 1, 0);
            while (reset_n === 1'b1 && bus_if.txd === 1'b0) @(negedge clk);
         end else begin
            e = sb_q.pop_front();
            bad = 0;
            got = 8'd0;
            aborted = 0;
            for (int k = 0; k < 10 * e.div; k++) begin
               if (k > 0) @(negedge clk);
               if (reset_n !== 1'b1) begin
                  aborted = 1;
                  break;
               end
               idx = k / e.div;
               if (idx == 0)      eb = 1'b0;
               else if (idx == 9) eb = 1'b1;
               else               eb = e.data[idx-1];
               if (bus_if.txd !== eb) bad++;
               if (idx >= 1 && idx <= 8 && (k % e.div) == e.div / 2) got[idx-1] = bus_if.txd;
            end
            if (!aborted) begin
               checkOutput("frame_byte", {24'd0, got}, {24'd0, e.data});
               checkOutput("frame_wave_bad_cycles", bad, 0);
               frames_done++;
            end
         end
      end
   end

   initial begin
      logic [31:0] rd;
      int last, e_cyc, fb, rise, irq_e1;

      vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h4};
      vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'd434};
      vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0};
      vecs[4]  = '{1'b1, 2'd2, 32'h0,         32'h0};
      vecs[5]  = '{1'b0, 2'd2, 32'h0,         32'h1};
      vecs[6]  = '{1'b1, 2'd2, 32'hABCD_1234, 32'h0};
      vecs[7]  = '{1'b0, 2'd2, 32'h0,         32'h1234};
      vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
      vecs[9]  = '{1'b0, 2'd3, 32'h0,         32'h1};
      vecs[10] = '{1'b1, 2'd3, 32'h0,         32'h0};
      vecs[11] = '{1'b0, 2'd3, 32'h0,         32'h0};
      vecs[12] = '{1'b1, 2'd1, 32'hFFFF_FFF7, 32'h0};
      vecs[13] = '{1'b0, 2'd1, 32'h0,         32'h4};
      vecs[14] = '{1'b1, 2'd1, 32'h8,         32'h0};
      vecs[15] = '{1'b0, 2'd1, 32'h0,         32'h4};

      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset state and one-cycle read latency.
      #1;
      checkOutput("reset_txd", bus_if.txd, 1);
      checkOutput("reset_irq", bus_if.irq, 0);
      checkOutput("reset_readdata", bus_if.readdata, 0);
      @(negedge clk);
      bus_if.address = 2'd2;
      #1;
      checkOutput("rd_latency_before_edge", bus_if.readdata, 0);
      @(posedge clk);
      #1;
      checkOutput("rd_latency_after_edge", bus_if.readdata, 434);

      $display("[TB] register table");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i], rd);
         if (!vecs[i].is_wr) checkOutput($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
      end

      $display("[TB] single frame 0xA5, divisor 4");
      busWrite(2'd2, 32'd4);
      starts.delete();
      fb = frames_done;
      sendByte(8'hA5, 1);
      e_cyc = last_wr_cyc;
      waitBusyEnd(200, last);
      waitFrames(fb + 1, 200);
      checkOutput("start_after_write", startAt(0) - e_cyc, 1);
      checkOutput("frame_len_div4", last - startAt(0), 40);
      busRead(2'd1, rd);
      checkOutput("status_after_frame", rd, 32'h4);

      $display("[TB] back-to-back frames 0x00, 0xFF");
      starts.delete();
      fb = frames_done;
      sendByte(8'h00, 1);
      sendByte(8'hFF, 1);
      waitBusyEnd(300, last);
      waitFrames(fb + 2, 300);
      checkOutput("second_start_gap", startAt(1) - startAt(0), 40);
      checkOutput("two_frame_len", last - startAt(0), 80);

      $display("[TB] FIFO full and overflow, divisor 1000");
      busWrite(2'd2, 32'd1000);
      fb = frames_done;
      sendByte(8'h11, 1);
      sendByte(8'h22, 1);
      sendByte(8'h33, 1);
      sendByte(8'h44, 1);
      sendByte(8'h55, 1);
      sendByte(8'h66, 0);
      busRead(2'd1, rd);
      checkOutput("status_full_ovf", rd, 32'hB);
      busRead(2'd0, rd);
      checkOutput("level_full", rd, 32'h4);
      busWrite(2'd1, 32'h8);
      busRead(2'd1, rd);
      checkOutput("status_ovf_cleared", rd, 32'h3);
      waitFrames(fb + 5, 60000);

      $display("[TB] divisor change mid-frame");
      busWrite(2'd2, 32'd8);
      starts.delete();
      fb = frames_done;
      sendByte(8'h5A, 1);
      repeat (30) @(posedge clk);
      busWrite(2'd2, 32'd2);
      waitBusyEnd(300, last);
      checkOutput("frame_len_old_div8", last - startAt(0), 80);
      sendByte(8'hC3, 1);
      waitBusyEnd(100, last);
      checkOutput("frame_len_div2", last - startAt(1), 20);
      busWrite(2'd2, 32'd0);
      busRead(2'd2, rd);
      checkOutput("div_zero_reads_one", rd, 32'h1);
      sendByte(8'h81, 1);
      waitBusyEnd(100, last);
      checkOutput("frame_len_div1", last - startAt(2), 10);
      waitFrames(fb + 3, 100);

      $display("[TB] interrupt and reset mid-frame");
      busWrite(2'd2, 32'd4);
      busWrite(2'd3, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("irq_idle_enabled", bus_if.irq, 1);
      fb = frames_done;
      sendByte(8'h3C, 1);
      e_cyc = last_wr_cyc;
      checkOutput("irq_at_push_edge", bus_if.irq, 1);
      rise = -1;
      irq_e1 = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) irq_e1 = int'(bus_if.irq);
         if (bus_if.irq) begin
            rise = cyc;
            break;
         end
      end
      checkOutput("irq_low_after_push", irq_e1, 0);
      checkOutput("irq_rise_cycle", rise - e_cyc, 42);
      waitFrames(fb + 1, 100);

      sendByte(8'h00, 1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("txd_low_in_data", bus_if.txd, 0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("txd_async_reset", bus_if.txd, 1);
      checkOutput("irq_async_reset", bus_if.irq, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      div_model = 434;
      busRead(2'd1, rd);
      checkOutput("status_after_reset", rd, 32'h4);
      busRead(2'd2, rd);
      checkOutput("div_after_reset", rd, 32'd434);
      busRead(2'd3, rd);
      checkOutput("ctrl_after_reset", rd, 32'h0);
      repeat (20) @(posedge clk);
      checkOutput("scoreboard_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
